// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Time-multiplexes a per-frame snapshot of hex/point/blank/blink onto the AN/SEG pins.
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hex,
  input  logic [3:0]  point,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        frame
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned FcW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [FcW-1:0]  FcLast  = FcW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {StD0, StD1, StD2, StD3} digit_e;

  digit_e          digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick, snap;
  logic            init_q;
  logic [15:0]     hex_q, hex_d;
  logic [3:0]      point_q, point_d;
  logic [3:0]      blank_q, blank_d;
  logic [3:0]      blink_q, blink_d;
  logic [FcW-1:0]  fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            frame_q;
  logic [1:0]      idx;
  logic [3:0]      nib;
  logic            dark;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = (cnt_q == CntLast);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    digit_d = digit_q;
    if (tick) begin
      unique case (digit_q)
        StD0: digit_d = StD1;
        StD1: digit_d = StD2;
        StD2: digit_d = StD3;
        StD3: digit_d = StD0;
      endcase
    end
  end

  // New frame: first clock out of reset, or the D3 -> D0 wrap.
  assign snap = init_q | (tick & (digit_q == StD3));

  always_comb begin
    hex_d   = hex_q;
    point_d = point_q;
    blank_d = blank_q;
    blink_d = blink_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (snap) begin
      hex_d   = hex;
      point_d = point;
      blank_d = blank;
      blink_d = blink;
      if (fcnt_q == FcLast) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Outputs are computed from next-state so the registered pins line up with the slot.
  // The anode stays dark on the clock the digit changes to avoid ghosting.
  always_comb begin
    idx   = digit_d;
    nib   = hex_d[{idx, 2'b00} +: 4];
    dark  = blank_d[idx] | (blink_d[idx] & phase_d);
    seg_d = {~point_d[idx], seg_decode(nib)};
    an_d  = 4'hF;
    if (!tick && !dark) begin
      an_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= StD0;
      init_q  <= 1'b1;
      hex_q   <= '0;
      point_q <= '0;
      blank_q <= '0;
      blink_q <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      init_q  <= 1'b0;
      hex_q   <= hex_d;
      point_q <= point_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= snap;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a cycle-arithmetic display model pushes expected pin states into a
// queue; a negedge monitor pops and compares them against the DUT.
module tb_disp_scan_ctrl;

  localparam int S  = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hex = 16'h1234;
  logic [3:0]  point = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink = '0;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        frame;

  disp_scan_ctrl #(
    .SCAN_DIV    (S),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .hex  (hex),
    .point(point),
    .blank(blank),
    .blink(blink),
    .AN   (AN),
    .SEG  (SEG),
    .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       seg_care;
    logic       frm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: clocks since reset release and snapshots taken so far.
  int          n = 0;
  int          snaps = 0;
  logic [15:0] s_hex;
  logic [3:0]  s_pt, s_bl, s_bk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t, n=%0d)", name, act, exp, $time, n);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("AN", {4'h0, AN}, {4'h0, mon_e.an});
      chk("frame", {7'h0, frame}, {7'h0, mon_e.frm});
      if (mon_e.seg_care) chk("SEG", SEG, mon_e.seg);
    end
  end

  task automatic step(input int cycles, input bit rnd);
    exp_t e;
    int   slot;
    bit   fr, dark, phase;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        e = '{4'hF, 8'hFF, 1'b1, 1'b0};
      end else begin
        n++;
        fr = (n == 1) || (n % (4 * S) == 0);
        if (fr) begin
          snaps++;
          s_hex = hex;
          s_pt  = point;
          s_bl  = blank;
          s_bk  = blink;
        end
        slot  = (n / S) % 4;
        phase = ((snaps / BF) % 2) == 1;
        dark  = s_bl[slot] || (s_bk[slot] && phase);
        e.frm = fr;
        e.an  = (n % S == 0 || dark) ? 4'hF : ~(4'b0001 << slot);
        e.seg = {~s_pt[slot], dec_tbl[s_hex[slot*4 +: 4]]};
        e.seg_care = !dark;
      end
      exp_q.push_back(e);
      if (rnd && $urandom_range(7) == 0) begin
        hex   = 16'($urandom);
        point = 4'($urandom);
        blank = 4'($urandom & $urandom & $urandom);
        blink = 4'($urandom);
      end
    end
  endtask

  initial begin
    step(3, 1'b0);
    rst = 1'b0;
    step(S + 1, 1'b0);
    hex = 16'hABCD;                     // lands in the D1 slot of the first frame
    step(3 * 4 * S, 1'b0);
    point = 4'b0101;
    hex   = 16'h8888;
    step(3 * 4 * S, 1'b0);
    point = 4'b0000;
    blank = 4'b1000;
    step(3 * 4 * S, 1'b0);
    blank = 4'b0000;
    blink = 4'b0001;
    step(8 * 4 * S, 1'b0);
    blink = 4'b0000;
    step(900, 1'b1);

    // Asynchronous reset in the middle of a D2 slot.
    while (n % (4 * S) != 2 * S + 2) step(1, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_AN", {4'h0, AN}, 8'h0F);
    chk("rst_SEG", SEG, 8'hFF);
    chk("rst_frame", {7'h0, frame}, 8'h00);
    n     = 0;
    snaps = 0;
    step(2, 1'b0);
    rst = 1'b0;
    step(300, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
